alu_status_stage: RTL

//  Execute stage directly downstream of the shifter/sign-extender: takes Rn and the shifter operand
//  (plus its shifter carry-out), performs the 16 ARM data-processing ops, and registers result and

---
 rtl/alu_status_stage.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/alu_status_stage.sv
// ARM data-processing execute stage: condition check against CPSR NZCV, 16-op ALU,
// and a 1-deep valid/ready result buffer that owns the flag register.
module alu_status_stage #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  cond,
  input  logic [3:0]  opcode,
  input  logic        s_bit,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        shift_cout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        wr_en,
  output logic        cond_fail,
  output logic [3:0]  flags
);

  localparam int unsigned W = 32;

  typedef enum logic [3:0] {
    OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
    OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
    OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
    OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
  } op_e;

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] result_q, result_d;
  logic         wr_en_q, wr_en_d;
  logic         cond_fail_q, cond_fail_d;
  logic [3:0]   flags_q, flags_d;

  logic         flag_n, flag_z, flag_c, flag_v;
  logic         accept_c;
  logic         cond_pass_c;
  logic         is_test_c;
  logic         is_arith_c;
  logic [W-1:0] add_x_c, add_y_c;
  logic         add_cin_c;
  logic [W:0]   sum_c;
  logic [W-1:0] alu_res_c;
  logic [3:0]   new_flags_c;

  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;
  assign in_ready = !out_valid_q || out_ready;
  assign accept_c = in_valid && in_ready;
  assign is_test_c = (opcode[3:2] == 2'b10);

  // Condition field evaluated against the registered flags.
  always_comb begin
    cond_pass_c = 1'b0;
    case (cond)
      4'h0: cond_pass_c = flag_z;
      4'h1: cond_pass_c = !flag_z;
      4'h2: cond_pass_c = flag_c;
      4'h3: cond_pass_c = !flag_c;
      4'h4: cond_pass_c = flag_n;
      4'h5: cond_pass_c = !flag_n;
      4'h6: cond_pass_c = flag_v;
      4'h7: cond_pass_c = !flag_v;
      4'h8: cond_pass_c = flag_c && !flag_z;
      4'h9: cond_pass_c = !flag_c || flag_z;
      4'hA: cond_pass_c = (flag_n == flag_v);
      4'hB: cond_pass_c = (flag_n != flag_v);
      4'hC: cond_pass_c = !flag_z && (flag_n == flag_v);
      4'hD: cond_pass_c = flag_z || (flag_n != flag_v);
      4'hE: cond_pass_c = 1'b1;
      default: cond_pass_c = 1'b0;
    endcase
  end

  // One shared 33-bit adder; subtracts are x + ~y + cin.
  always_comb begin
    is_arith_c = 1'b1;
    add_x_c    = op_a;
    add_y_c    = op_b;
    add_cin_c  = 1'b0;
    alu_res_c  = '0;
    case (op_e'(opcode))
      OP_SUB, OP_CMP: begin add_y_c = ~op_b; add_cin_c = 1'b1; end
      OP_RSB:         begin add_x_c = op_b; add_y_c = ~op_a; add_cin_c = 1'b1; end
      OP_ADD, OP_CMN: add_cin_c = 1'b0;
      OP_ADC:         add_cin_c = flag_c;
      OP_SBC:         begin add_y_c = ~op_b; add_cin_c = flag_c; end
      OP_RSC:         begin add_x_c = op_b; add_y_c = ~op_a; add_cin_c = flag_c; end
      OP_AND, OP_TST: begin is_arith_c = 1'b0; alu_res_c = op_a & op_b; end
      OP_EOR, OP_TEQ: begin is_arith_c = 1'b0; alu_res_c = op_a ^ op_b; end
      OP_ORR:         begin is_arith_c = 1'b0; alu_res_c = op_a | op_b; end
      OP_MOV:         begin is_arith_c = 1'b0; alu_res_c = op_b; end
      OP_BIC:         begin is_arith_c = 1'b0; alu_res_c = op_a & ~op_b; end
      default:        begin is_arith_c = 1'b0; alu_res_c = ~op_b; end
    endcase
    sum_c = (W+1)'(add_x_c) + (W+1)'(add_y_c) + (W+1)'(add_cin_c);
    if (is_arith_c) begin
      alu_res_c   = sum_c[W-1:0];
      new_flags_c = {sum_c[W-1], (sum_c[W-1:0] == '0), sum_c[W],
                     (add_x_c[W-1] == add_y_c[W-1]) && (sum_c[W-1] != add_x_c[W-1])};
    end else begin
      new_flags_c = {alu_res_c[W-1], (alu_res_c == '0), shift_cout, flag_v};
    end
  end

  // Buffer next-state: accept (possibly with simultaneous drain) or drain.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    wr_en_d     = wr_en_q;
    cond_fail_d = cond_fail_q;
    flags_d     = flags_q;
    if (accept_c) begin
      out_valid_d = 1'b1;
      if (cond_pass_c) begin
        result_d    = alu_res_c;
        wr_en_d     = !is_test_c;
        cond_fail_d = 1'b0;
        if (s_bit || is_test_c) begin
          flags_d = new_flags_c;
        end
      end else begin
        result_d    = '0;
        wr_en_d     = 1'b0;
        cond_fail_d = 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      wr_en_q     <= 1'b0;
      cond_fail_q <= 1'b0;
      flags_q     <= RESET_FLAGS;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      wr_en_q     <= wr_en_d;
      cond_fail_q <= cond_fail_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign wr_en     = wr_en_q;
  assign cond_fail = cond_fail_q;
  assign flags     = flags_q;

endmodule
